// File: rtl/tpu_matmul_engine.sv
// rtl/tpu_matmul_engine.sv - NxN signed matrix engine: byte-serial operand load, N-cycle PE array compute, byte-serial result stream
module tpu_matmul_engine #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mode_transpose,
  input  logic       mode_elemwise,
  input  logic       mode_relu,
  input  logic       abort,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int BPR = ACC_W / 8;
  localparam int BCW = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [KW-1:0]  K_LAST = KW'(N - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(BPR - 1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  state_t state, state_next;

  logic [KW-1:0]  ld_row, ld_col, k_cnt, out_row, out_col;
  logic           ld_b;
  logic [BCW-1:0] byte_cnt;
  logic           mode_tr, mode_el, mode_rl;

  logic signed [DATA_W-1:0] a_mem [N][N];
  logic signed [DATA_W-1:0] b_mem [N][N];
  logic        [ACC_W-1:0]  acc   [N][N];
  logic        [ACC_W-1:0]  mac   [N][N];
  logic        [ACC_W-1:0]  cur;

  logic load_fire, load_done, out_fire, out_done;

  // The load counter is kept as (matrix, row, col) so no division is needed for odd N.
  assign load_fire = (state == S_LOAD) && in_valid;
  assign load_done = load_fire && ld_b && (ld_row == K_LAST) && (ld_col == K_LAST);
  assign out_fire  = (state == S_OUTPUT) && out_ready;
  assign out_done  = out_fire && (out_row == K_LAST) && (out_col == K_LAST) && (byte_cnt == B_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_LOAD;
    end else begin
      case (state)
        S_LOAD:    if (load_done) state_next = S_COMPUTE;
        S_COMPUTE: if (k_cnt == K_LAST) state_next = S_OUTPUT;
        S_OUTPUT:  if (out_done) state_next = S_LOAD;
        default:   state_next = S_LOAD;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    cur       = acc[out_row][out_col] >> {byte_cnt, 3'b000};
    case (state)
      S_LOAD:    in_ready = 1'b1;
      S_COMPUTE: busy = 1'b1;
      S_OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (out_row == K_LAST) && (out_col == K_LAST) && (byte_cnt == B_LAST);
        // ReLU is a whole-result decision, so every byte of a negative result is zeroed.
        out_data  = (mode_rl && acc[out_row][out_col][ACC_W-1]) ? 8'h00 : cur[7:0];
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_pe
      logic signed [2*DATA_W-1:0] op_a, op_b, prod;
      always_comb begin
        op_a = a_mem[gi][k_cnt];
        op_b = b_mem[k_cnt][gj];
        if (mode_el) begin
          op_a = a_mem[gi][gj];
          op_b = b_mem[gi][gj];
        end else if (mode_tr) begin
          op_b = b_mem[gj][k_cnt];
        end
      end
      assign prod         = op_a * op_b;
      assign mac[gi][gj]  = ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_row   <= '0;
      ld_col   <= '0;
      ld_b     <= 1'b0;
      k_cnt    <= '0;
      out_row  <= '0;
      out_col  <= '0;
      byte_cnt <= '0;
      mode_tr  <= 1'b0;
      mode_el  <= 1'b0;
      mode_rl  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else if (abort) begin
      ld_row   <= '0;
      ld_col   <= '0;
      ld_b     <= 1'b0;
      k_cnt    <= '0;
      out_row  <= '0;
      out_col  <= '0;
      byte_cnt <= '0;
      mode_tr  <= 1'b0;
      mode_el  <= 1'b0;
      mode_rl  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else begin
      case (state)
        S_LOAD: begin
          if (load_fire) begin
            if (ld_b) b_mem[ld_row][ld_col] <= in_data;
            else      a_mem[ld_row][ld_col] <= in_data;
            if (ld_col == K_LAST) begin
              ld_col <= '0;
              if (ld_row == K_LAST) begin
                ld_row <= '0;
                ld_b   <= ~ld_b;
              end else begin
                ld_row <= ld_row + 1'b1;
              end
            end else begin
              ld_col <= ld_col + 1'b1;
            end
          end
          if (load_done) begin
            mode_tr <= mode_transpose;
            mode_el <= mode_elemwise;
            mode_rl <= mode_relu;
            k_cnt   <= '0;
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                acc[i][j] <= '0;
          end
        end
        S_COMPUTE: begin
          k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              if (!mode_el)           acc[i][j] <= acc[i][j] + mac[i][j];
              else if (k_cnt == '0)   acc[i][j] <= mac[i][j];
            end
          end
        end
        S_OUTPUT: begin
          if (out_fire) begin
            if (byte_cnt == B_LAST) begin
              byte_cnt <= '0;
              if (out_col == K_LAST) begin
                out_col <= '0;
                out_row <= (out_row == K_LAST) ? '0 : out_row + 1'b1;
              end else begin
                out_col <= out_col + 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_matmul_engine.sv
// tb/tb_tpu_matmul_engine.sv - directed bench for tpu_matmul_engine (N=2, 16-bit results)
module tb_tpu_matmul_engine;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mode_transpose, mode_elemwise, mode_relu;
  logic       abort;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  tpu_matmul_engine #(.N(N), .DATA_W(8), .ACC_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mode_transpose (mode_transpose),
    .mode_elemwise  (mode_elemwise),
    .mode_relu      (mode_relu),
    .abort          (abort),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Operand and result vectors are packed byte0-at-LSB: A row-major then B row-major.
  localparam logic [63:0] OPS_AB   = 64'h0807_0605_0403_0201;
  localparam logic [63:0] OPS_NEG  = 64'h0100_0001_0100_00FF;
  localparam logic [63:0] OPS_EXT  = 64'h8080_8080_7F7F_7F7F;
  localparam logic [63:0] EXP_MUL  = 64'h0032_002B_0016_0013;
  localparam logic [63:0] EXP_TR   = 64'h0035_0027_0017_0011;
  localparam logic [63:0] EXP_EL   = 64'h0020_0015_000C_0005;
  localparam logic [63:0] EXP_NEG  = 64'h0001_0000_0000_FFFF;
  localparam logic [63:0] EXP_RELU = 64'h0001_0000_0000_0000;
  localparam logic [63:0] EXP_EXT  = 64'h8100_8100_8100_8100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_ops(input logic [63:0] ops, input int nbytes,
                          input logic tr, input logic el, input logic rl);
    mode_transpose = tr;
    mode_elemwise  = el;
    mode_relu      = rl;
    for (int i = 0; i < nbytes; i++) begin
      in_valid = 1'b1;
      in_data  = ops[8*i +: 8];
      @(posedge clk);
      #1;
    end
    in_valid       = 1'b0;
    // Modes must only matter at the final acceptance edge.
    mode_transpose = ~tr;
    mode_elemwise  = ~el;
    mode_relu      = ~rl;
  endtask

  task automatic expect_output(input string tag, input logic [63:0] exp,
                               input logic stall, input logic junk);
    int c;
    logic [9:0] held;
    c = 0;
    @(negedge clk);
    check({tag, ":compute_flags"}, {busy, in_ready}, 2'b10);
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check({tag, ":latency"}, c, N);
    for (int b = 0; b < 8; b++) begin
      if (b > 0) @(negedge clk);
      check($sformatf("%s:byte%0d", tag, b), {out_valid, out_last, out_data},
            {1'b1, (b == 7), exp[8*b +: 8]});
      if (junk) begin
        in_valid = (b < 7);
        in_data  = 8'hA5;
      end
      if (stall && b == 2) begin
        held      = {out_valid, out_last, out_data};
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check($sformatf("%s:stall%0d", tag, s), {out_valid, out_last, out_data},
                {1'b1, 1'b0, exp[23:16]});
        end
        check({tag, ":stall_hold"}, {out_valid, out_last, out_data}, held);
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, ":done_flags"}, {out_valid, in_ready, busy}, 3'b010);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int c;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    mode_transpose = 1'b0; mode_elemwise = 1'b0; mode_relu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {in_ready, busy, out_valid, out_last, out_data}, 12'h800);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    load_ops(OPS_AB, 8, 1'b0, 1'b0, 1'b0);
    expect_output("mul_junk", EXP_MUL, 1'b0, 1'b1);
    load_ops(OPS_AB, 8, 1'b1, 1'b0, 1'b0);
    expect_output("transpose_stall", EXP_TR, 1'b1, 1'b0);
    load_ops(OPS_AB, 8, 1'b1, 1'b1, 1'b0);
    expect_output("elemwise", EXP_EL, 1'b0, 1'b0);
    load_ops(OPS_NEG, 8, 1'b0, 1'b0, 1'b0);
    expect_output("signed", EXP_NEG, 1'b0, 1'b0);
    load_ops(OPS_NEG, 8, 1'b0, 1'b0, 1'b1);
    expect_output("relu", EXP_RELU, 1'b0, 1'b0);
    load_ops(OPS_EXT, 8, 1'b0, 1'b0, 1'b0);
    expect_output("extremes", EXP_EXT, 1'b0, 1'b0);

    // Abort mid-LOAD: the three partial bytes must not shift the next job.
    load_ops(OPS_EXT, 3, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_load_ready", {in_ready, busy}, 2'b10);
    load_ops(OPS_AB, 8, 1'b0, 1'b0, 1'b0);
    expect_output("after_abort_load", EXP_MUL, 1'b0, 1'b0);

    // Abort during COMPUTE.
    load_ops(OPS_AB, 8, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_compute", {in_ready, busy, out_valid}, 3'b100);
    @(posedge clk);
    #1;
    load_ops(OPS_EXT, 8, 1'b0, 1'b0, 1'b0);
    expect_output("after_abort_compute", EXP_EXT, 1'b0, 1'b0);

    // Asynchronous reset mid-OUTPUT.
    load_ops(OPS_AB, 8, 1'b0, 1'b0, 1'b0);
    c = 0;
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("reset_mid_out_started", {out_valid, out_data}, 9'h113);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_out", {in_ready, busy, out_valid, out_last, out_data}, 12'h800);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_ops(OPS_AB, 8, 1'b1, 1'b0, 1'b0);
    expect_output("after_reset", EXP_TR, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
